// File: rtl/serial_five_bit_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_five_bit_subtractor
// Description : Bit-serial subtractor, diff = (a - b) mod 2**WIDTH, LSB first,
//               one bit per clock, with a borrow flag and start/busy/done
//               handshake.
// Revision    : 1.0  initial release
// ============================================================================
module serial_five_bit_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Counter value of the final (MSB) bit step.
    localparam logic [2:0] C_LAST_BIT = 3'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] sa_q,     sa_d;
    logic [WIDTH-1:0] sb_q,     sb_d;
    logic [WIDTH-1:0] sr_q,     sr_d;
    logic             c_q,      c_d;
    logic [2:0]       cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // One full-adder slice: sa holds a, sb holds ~b, carry starts at 1.
    logic w_sum;
    logic w_carry;
    assign w_sum   = sa_q[0] ^ sb_q[0] ^ c_q;
    assign w_carry = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = ~b;
                    c_d     = 1'b1;
                    cnt_d   = 3'd0;
                    sr_d    = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d  = {w_sum, sr_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = w_carry;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == C_LAST_BIT) begin
                    diff_d   = {w_sum, sr_q[WIDTH-1:1]};
                    borrow_d = ~w_carry;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flags are registered from the next state so they are glitch-free
        // and track the state register exactly.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            c_q      <= 1'b0;
            cnt_q    <= 3'd0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_five_bit_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_five_bit_subtractor
// Description : Self-checking bench for serial_five_bit_subtractor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_five_bit_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] a;
    logic [4:0] b;
    logic       busy;
    logic       done;
    logic [4:0] diff;
    logic       borrow;

    int n_tests = 0;
    int n_fail  = 0;

    serial_five_bit_subtractor #(.WIDTH(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] va;
        logic [4:0] vb;
        logic [4:0] exp_diff;
        logic       exp_borrow;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Issue one single-cycle request and follow it through to idle.
    task automatic run_op(input logic [4:0] ta, input logic [4:0] tb,
                          input logic [4:0] ed, input logic eb);
        logic [4:0] pd;
        logic       pb;
        int         n;
        @(negedge clk);
        pd    = diff;
        pb    = borrow;
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            check("busy_during_op", int'(busy), 1);
            check("diff_hold", int'(diff), int'(pd));
            check("borrow_hold", int'(borrow), int'(pb));
            @(posedge clk); #1;
            n++;
        end
        check("done_latency", n, 5);
        check("diff", int'(diff), int'(ed));
        check("borrow", int'(borrow), int'(eb));
        check("busy_in_done", int'(busy), 1);
        @(posedge clk); #1;
        check("done_single", int'(done), 0);
        check("busy_fall", int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{5'd13, 5'd5,  5'd8,  1'b0};
        vecs[1] = '{5'd5,  5'd13, 5'd24, 1'b1};
        vecs[2] = '{5'd0,  5'd1,  5'd31, 1'b1};
        vecs[3] = '{5'd31, 5'd31, 5'd0,  1'b0};
        vecs[4] = '{5'd0,  5'd0,  5'd0,  1'b0};
        vecs[5] = '{5'd31, 5'd0,  5'd31, 1'b0};
        vecs[6] = '{5'd20, 5'd3,  5'd17, 1'b0};
        vecs[7] = '{5'd9,  5'd2,  5'd7,  1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = 5'd0;
        b     = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_borrow", int'(borrow), 0);
        // Reset beats start.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        check("rst_over_start", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_diff, vecs[i].exp_borrow);

        // Exhaustive operand sweep against a modular model.
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                run_op(5'(i), 5'(j), 5'((i - j) & 31), (i < j));
            end
        end

        // Leave a nonzero prior result, then start while busy.
        run_op(5'd0, 5'd1, 5'd31, 1'b1);
        begin
            int ndone;
            ndone = 0;
            @(negedge clk);
            start = 1'b1; a = 5'd9; b = 5'd2;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 0; k < 14; k++) begin
                if (k == 1) begin
                    @(negedge clk);
                    start = 1'b1; a = 5'd1; b = 5'd30;
                    @(posedge clk); #1;
                    start = 1'b0;
                end else if (k > 1) begin
                    @(posedge clk); #1;
                end
                if (k < 5) check("busy_hold_diff", int'(diff), 31);
                if (k == 5) begin
                    check("busy_start_done", int'(done), 1);
                    check("busy_start_diff", int'(diff), 7);
                    check("busy_start_borrow", int'(borrow), 0);
                end
                if (done) ndone++;
            end
            check("busy_start_done_count", ndone, 1);
        end

        // Held start: one operation every 7 cycles.
        @(negedge clk);
        start = 1'b1; a = 5'd20; b = 5'd3;
        @(posedge clk); #1;
        for (int k = 0; k < 28; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check("held_done", int'(done), int'((k % 7) == 5));
            check("held_busy", int'(busy), int'((k % 7) != 6));
            if ((k % 7) == 5) check("held_diff", int'(diff), 17);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held_idle", int'(busy), 0);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; a = 5'd20; b = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_diff", int'(diff), 0);
        check("midrst_borrow", int'(borrow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int ndone;
            ndone = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #1;
                if (done) ndone++;
            end
            check("midrst_no_done", ndone, 0);
        end
        run_op(5'd20, 5'd3, 5'd17, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
